// File: rtl/slice_volume_integrator_pkg.sv
// Shared state encoding, default widths and drain length for the slice volume integrator.
package vol_pkg;

    localparam int unsigned SURF_W_DEF = 32;
    localparam int unsigned DZ_W_DEF   = 16;
    localparam int unsigned VOL_W_DEF  = 64;
    localparam int unsigned CNT_W_DEF  = 10;

    // Cycles spent in DRAIN; covers the 2-cycle MAC pipeline so acc is final at DONE.
    localparam int unsigned DRAIN_CYC = 2;

    typedef enum logic [2:0] {IDLE, WAIT_FIRST, ACCUM, DRAIN, DONE} vol_state_t;

endpackage

// File: rtl/slice_volume_integrator_mac.sv
// Two-stage trapezoid MAC: stage 1 adds neighbouring surfaces, stage 2 scales by dz and
// accumulates into a VOL_W+1 bit register that saturates and flags on carry-out.
module slice_trap_mac
    import vol_pkg::*;
#(
    parameter int unsigned SURF_W = SURF_W_DEF,
    parameter int unsigned DZ_W   = DZ_W_DEF,
    parameter int unsigned VOL_W  = VOL_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              issue,
    input  logic [SURF_W-1:0] a,
    input  logic [SURF_W-1:0] b,
    input  logic [DZ_W-1:0]   dz,
    output logic [VOL_W:0]    acc,
    output logic              ovf
);

    localparam int unsigned AW = VOL_W + 1;
    localparam int unsigned PW = SURF_W + 1 + DZ_W;

    logic [SURF_W:0] sum_q;
    logic            v1_q;
    logic [PW-1:0]   prod;
    logic [AW:0]     acc_nx;

    always_comb begin
        prod   = PW'(sum_q) * PW'(dz);
        acc_nx = {1'b0, acc} + (AW + 1)'(prod);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sum_q <= '0;
            v1_q  <= 1'b0;
            acc   <= '0;
            ovf   <= 1'b0;
        end else if (clear) begin
            sum_q <= '0;
            v1_q  <= 1'b0;
            acc   <= '0;
            ovf   <= 1'b0;
        end else begin
            v1_q <= issue;
            if (issue) begin
                sum_q <= {1'b0, a} + {1'b0, b};
            end
            // Once saturated the accumulator is frozen for the rest of the scan.
            if (v1_q && !ovf) begin
                if (acc_nx[AW]) begin
                    acc <= '1;
                    ovf <= 1'b1;
                end else begin
                    acc <= acc_nx[AW-1:0];
                end
            end
        end
    end

endmodule

// File: rtl/slice_volume_integrator.sv
// Scan-volume integrator: frames a scan with start/stop, counts surface results on rdy rising
// edges and feeds neighbouring pairs into the trapezoid MAC; posts one result strobe per scan.
module slice_volume_integrator
    import vol_pkg::*;
#(
    parameter int unsigned SURF_W = SURF_W_DEF,
    parameter int unsigned DZ_W   = DZ_W_DEF,
    parameter int unsigned VOL_W  = VOL_W_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic [DZ_W-1:0]   dz,
    input  logic              surf_rdy,
    input  logic [SURF_W-1:0] surf,
    output logic              busy,
    output logic              vol_valid,
    output logic [VOL_W-1:0]  volume,
    output logic [CNT_W-1:0]  slice_cnt,
    output logic              overflow
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    vol_state_t        state_q;
    logic              rdy_q;
    logic [DZ_W-1:0]   dz_q;
    logic [SURF_W-1:0] prev_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              cnt_ovf_q;
    logic [1:0]        drain_q;

    logic              acc_ev;
    logic              mac_issue;
    logic [VOL_W:0]    acc;
    logic              mac_ovf;

    always_comb begin
        acc_ev    = surf_rdy & ~rdy_q;
        // A restart aborts the scan, so it must not also push a surface into the MAC.
        mac_issue = (state_q == ACCUM) && acc_ev && !start && (cnt_q != CNT_MAX);
        busy      = (state_q != IDLE);
    end

    slice_trap_mac #(
        .SURF_W(SURF_W),
        .DZ_W  (DZ_W),
        .VOL_W (VOL_W)
    ) u_mac (
        .clk  (clk),
        .rst  (rst),
        .clear(start),
        .issue(mac_issue),
        .a    (prev_q),
        .b    (surf),
        .dz   (dz_q),
        .acc  (acc),
        .ovf  (mac_ovf)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            rdy_q     <= 1'b0;
            dz_q      <= '0;
            prev_q    <= '0;
            cnt_q     <= '0;
            cnt_ovf_q <= 1'b0;
            drain_q   <= '0;
            vol_valid <= 1'b0;
            volume    <= '0;
            slice_cnt <= '0;
            overflow  <= 1'b0;
        end else begin
            rdy_q     <= surf_rdy;
            vol_valid <= 1'b0;
            if (start) begin
                state_q   <= WAIT_FIRST;
                dz_q      <= dz;
                cnt_q     <= '0;
                cnt_ovf_q <= 1'b0;
            end else begin
                unique case (state_q)
                    IDLE: ;
                    WAIT_FIRST, ACCUM: begin
                        if (acc_ev) begin
                            if (cnt_q == CNT_MAX) begin
                                cnt_ovf_q <= 1'b1;
                            end else begin
                                prev_q <= surf;
                                cnt_q  <= cnt_q + 1'b1;
                                if (state_q == WAIT_FIRST) begin
                                    state_q <= ACCUM;
                                end
                            end
                        end
                        if (stop) begin
                            state_q <= DRAIN;
                            drain_q <= '0;
                        end
                    end
                    DRAIN: begin
                        if (drain_q == 2'(DRAIN_CYC - 1)) begin
                            state_q   <= DONE;
                            vol_valid <= 1'b1;
                            volume    <= acc[VOL_W:1];
                            slice_cnt <= cnt_q;
                            overflow  <= cnt_ovf_q | mac_ovf;
                        end else begin
                            drain_q <= drain_q + 1'b1;
                        end
                    end
                    DONE:    state_q <= IDLE;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

endmodule
